// File: rtl/connector_pkg.sv
// Shared trace-encoder constants and the block bundle
// carried from the connector to the encoder input.
package connector_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned IRETIRE_LEN = 32;
  localparam int unsigned ITYPE_LEN   = 3;
  localparam int unsigned PRIV_LEN    = 2;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
    logic [XLEN-1:0]        cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
  } te_block_s;

endpackage

// File: rtl/te_block_serializer_compactor.sv
// Squeezes valid lanes into consecutive slots and
// reports how many slots are in use.
module te_lane_compactor
  import connector_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned KW = $clog2(N+1)
) (
  input  logic [N-1:0]   valid_i,
  input  te_block_s      blk_i  [N],
  output te_block_s      slot_o [N],
  output logic [KW-1:0]  k_o
);

  logic [KW-1:0] cnt;

  // prefix popcount picks each valid lane's slot
  always_comb begin
    cnt = '0;
    for (int j = 0; j < N; j++) begin
      slot_o[j] = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (valid_i[i]) begin
        for (int j = 0; j < N; j++) begin
          if (cnt == KW'(j)) begin
            slot_o[j] = blk_i[i];
          end
        end
        cnt = cnt + KW'(1);
      end
    end
    k_o = cnt;
  end

endmodule

// File: rtl/te_block_serializer.sv
// Elastic N-in / 1-out block buffer between the
// connector and a single-lane trace encoder.
module te_block_serializer
  import connector_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [N-1:0]                      valid_i,
  input  logic [N-1:0][IRETIRE_LEN-1:0]     iretire_i,
  input  logic [N-1:0]                      ilastsize_i,
  input  logic [N-1:0][ITYPE_LEN-1:0]       itype_i,
  input  logic [N-1:0][XLEN-1:0]            iaddr_i,
  input  logic [XLEN-1:0]                   cause_i,
  input  logic [XLEN-1:0]                   tval_i,
  input  logic [PRIV_LEN-1:0]               priv_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [IRETIRE_LEN-1:0]            iretire_o,
  output logic                              ilastsize_o,
  output logic [ITYPE_LEN-1:0]              itype_o,
  output logic [XLEN-1:0]                   iaddr_o,
  output logic [XLEN-1:0]                   cause_o,
  output logic [XLEN-1:0]                   tval_o,
  output logic [PRIV_LEN-1:0]               priv_o,
  output logic [$clog2(DEPTH):0]            usage_o,
  output logic                              overflow_o,
  output logic [CNT_W-1:0]                  drop_cnt_o,
  input  logic                              clear_ovf_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned UW = PW + 1;
  localparam int unsigned KW = $clog2(N+1);

  te_block_s         blk  [N];
  te_block_s         slot [N];
  te_block_s         mem_q [DEPTH];
  te_block_s         head;
  logic [KW-1:0]     k;
  logic [UW-1:0]     k_u;
  logic [UW-1:0]     free;
  logic              accept;
  logic              drop;
  logic              pop;
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [UW-1:0]     usage_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  drop_q;
  logic [CNT_W-1:0]  base;
  logic [CNT_W:0]    sum;
  logic [CNT_W-1:0]  drop_nx;

  // per-cycle fields ride along with every lane
  always_comb begin
    for (int i = 0; i < N; i++) begin
      blk[i].iretire   = iretire_i[i];
      blk[i].ilastsize = ilastsize_i[i];
      blk[i].itype     = itype_i[i];
      blk[i].iaddr     = iaddr_i[i];
      blk[i].cause     = cause_i;
      blk[i].tval      = tval_i;
      blk[i].priv      = priv_i;
    end
  end

  te_lane_compactor #(
    .N  (N),
    .KW (KW)
  ) u_compactor (
    .valid_i (valid_i),
    .blk_i   (blk),
    .slot_o  (slot),
    .k_o     (k)
  );

  // all-or-nothing admission against pre-edge space
  always_comb begin
    k_u    = UW'(k);
    free   = UW'(DEPTH) - usage_q;
    accept = (k_u <= free);
    drop   = !accept;
    pop    = valid_o && ready_i;
    base   = clear_ovf_i ? '0 : drop_q;
    sum    = {1'b0, base} + (CNT_W+1)'(k);
    drop_nx = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  // storage write; occupancy lives in the pointers
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (KW'(i) < k) begin
          mem_q[wr_q + PW'(i)] <= slot[i];
        end
      end
    end
  end

  // pointers, occupancy and loss reporting
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      usage_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (accept) begin
        wr_q <= wr_q + PW'(k);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      usage_q <= usage_q + (accept ? k_u : '0) - UW'(pop);
      if (drop) begin
        ovf_q  <= 1'b1;
        drop_q <= drop_nx;
      end else if (clear_ovf_i) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  // head block, zeroed while empty
  always_comb begin
    valid_o = (usage_q != '0);
    head    = valid_o ? mem_q[rd_q] : '0;
    iretire_o   = head.iretire;
    ilastsize_o = head.ilastsize;
    itype_o     = head.itype;
    iaddr_o     = head.iaddr;
    cause_o     = head.cause;
    tval_o      = head.tval;
    priv_o      = head.priv;
  end

  assign usage_o    = usage_q;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_te_block_serializer.sv
// Scoreboard bench: block-level queue model vs the
// serializer, random and directed traffic.
module tb_te_block_serializer;
  import connector_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int UW    = $clog2(DEPTH) + 1;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [N-1:0]                  valid_i;
  logic [N-1:0][IRETIRE_LEN-1:0] iretire_i;
  logic [N-1:0]                  ilastsize_i;
  logic [N-1:0][ITYPE_LEN-1:0]   itype_i;
  logic [N-1:0][XLEN-1:0]        iaddr_i;
  logic [XLEN-1:0]               cause_i;
  logic [XLEN-1:0]               tval_i;
  logic [PRIV_LEN-1:0]           priv_i;
  logic                          valid_o;
  logic                          ready_i;
  logic [IRETIRE_LEN-1:0]        iretire_o;
  logic                          ilastsize_o;
  logic [ITYPE_LEN-1:0]          itype_o;
  logic [XLEN-1:0]               iaddr_o;
  logic [XLEN-1:0]               cause_o;
  logic [XLEN-1:0]               tval_o;
  logic [PRIV_LEN-1:0]           priv_o;
  logic [UW-1:0]                 usage_o;
  logic                          overflow_o;
  logic [CNT_W-1:0]              drop_cnt_o;
  logic                          clear_ovf_i;

  logic [N-1:0][IRETIRE_LEN-1:0] s_iretire;
  logic [N-1:0]                  s_ilast;
  logic [N-1:0][ITYPE_LEN-1:0]   s_itype;
  logic [N-1:0][XLEN-1:0]        s_iaddr;
  logic [XLEN-1:0]               s_cause;
  logic [XLEN-1:0]               s_tval;
  logic [PRIV_LEN-1:0]           s_priv;

  te_block_s exp_q[$];
  te_block_s e;
  te_block_s act;
  int  exp_usage;
  int  exp_drop;
  bit  exp_ovf;
  int  p_k;
  bit  p_acc;
  bit  p_pop;
  bit  p_clr;
  int  checks;
  int  passed;
  bit  checking;

  always #5 clk_i = ~clk_i;

  te_block_serializer #(
    .N     (N),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .iretire_i   (iretire_i),
    .ilastsize_i (ilastsize_i),
    .itype_i     (itype_i),
    .iaddr_i     (iaddr_i),
    .cause_i     (cause_i),
    .tval_i      (tval_i),
    .priv_i      (priv_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .iretire_o   (iretire_o),
    .ilastsize_o (ilastsize_o),
    .itype_o     (itype_o),
    .iaddr_o     (iaddr_o),
    .cause_o     (cause_o),
    .tval_o      (tval_o),
    .priv_o      (priv_o),
    .usage_o     (usage_o),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o),
    .clear_ovf_i (clear_ovf_i)
  );

  task automatic chk(input string name,
                     input logic [159:0] a,
                     input logic [159:0] x);
    checks++;
    if (a === x) passed++;
    else $display("FAIL %s actual=%0h required=%0h",
                  name, a, x);
  endtask

  // monitor: state checks plus head pop/compare
  initial begin
    forever begin
      @(negedge clk_i);
      if (checking) begin
        chk("usage", 160'(usage_o), 160'(exp_usage));
        chk("valid", 160'(valid_o), 160'(exp_usage != 0));
        chk("overflow", 160'(overflow_o), 160'(exp_ovf));
        chk("drop_cnt", 160'(drop_cnt_o), 160'(exp_drop));
        act = '{iretire: iretire_o, ilastsize: ilastsize_o,
                itype: itype_o, iaddr: iaddr_o,
                cause: cause_o, tval: tval_o, priv: priv_o};
        if (valid_o) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_block", 160'(act), 160'(0));
          end else begin
            e = exp_q[0];
            chk("head_block", 160'(act), 160'(e));
            if (ready_i) void'(exp_q.pop_front());
          end
        end else begin
          chk("idle_data", 160'(act), 160'(0));
        end
      end
    end
  end

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      s_iretire[i] = $urandom;
      s_ilast[i]   = 1'($urandom);
      s_itype[i]   = ITYPE_LEN'($urandom);
      s_iaddr[i]   = $urandom;
    end
    s_cause = $urandom;
    s_tval  = $urandom;
    s_priv  = PRIV_LEN'($urandom);
  endtask

  // one cycle: settle model from last edge, apply new
  task automatic step(input logic [N-1:0] v,
                      input logic rdy,
                      input logic clr);
    te_block_s b;
    int k;
    @(posedge clk_i);
    #1;
    if (p_k > 0 && !p_acc) begin
      exp_ovf  = 1'b1;
      exp_drop = (p_clr ? 0 : exp_drop) + p_k;
      if (exp_drop > SAT) exp_drop = SAT;
    end else if (p_clr) begin
      exp_ovf  = 1'b0;
      exp_drop = 0;
    end
    if (p_acc) exp_usage += p_k;
    if (p_pop) exp_usage -= 1;
    valid_i     = v;
    ready_i     = rdy;
    clear_ovf_i = clr;
    iretire_i   = s_iretire;
    ilastsize_i = s_ilast;
    itype_i     = s_itype;
    iaddr_i     = s_iaddr;
    cause_i     = s_cause;
    tval_i      = s_tval;
    priv_i      = s_priv;
    k     = $countones(v);
    p_k   = k;
    p_acc = (k <= DEPTH - exp_usage);
    p_pop = (exp_usage != 0) && rdy;
    p_clr = clr;
    if (p_acc) begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          b = '{iretire: s_iretire[i], ilastsize: s_ilast[i],
                itype: s_itype[i], iaddr: s_iaddr[i],
                cause: s_cause, tval: s_tval, priv: s_priv};
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic do_reset();
    checking    = 1'b0;
    rst_ni      = 1'b0;
    valid_i     = '0;
    ready_i     = 1'b0;
    clear_ovf_i = 1'b0;
    iretire_i   = '0;
    ilastsize_i = '0;
    itype_i     = '0;
    iaddr_i     = '0;
    cause_i     = '0;
    tval_i      = '0;
    priv_i      = '0;
    exp_q.delete();
    exp_usage = 0;
    exp_drop  = 0;
    exp_ovf   = 1'b0;
    p_k = 0; p_acc = 1'b1; p_pop = 1'b0; p_clr = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni   = 1'b1;
    checking = 1'b1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rand_data();
    do_reset();
    repeat (3) step('0, 1'b1, 1'b0);

    rand_data();
    s_iaddr[0] = 32'h8000_0000;
    s_iaddr[1] = 32'h8000_0010;
    step(2'b11, 1'b1, 1'b0);
    repeat (3) step('0, 1'b1, 1'b0);

    rand_data();
    s_iaddr[1] = 32'h0000_1234;
    step(2'b10, 1'b1, 1'b0);
    repeat (2) step('0, 1'b1, 1'b0);

    rand_data(); step(2'b11, 1'b0, 1'b0);
    rand_data(); step(2'b11, 1'b0, 1'b0);
    rand_data(); step(2'b01, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("full_drop_ovf", 160'(overflow_o), 160'(1));
    chk("full_drop_cnt", 160'(drop_cnt_o), 160'(1));
    chk("full_usage", 160'(usage_o), 160'(4));
    repeat (5) step('0, 1'b1, 1'b0);

    rand_data(); step(2'b11, 1'b0, 1'b0);
    rand_data(); step(2'b01, 1'b0, 1'b0);
    rand_data(); step(2'b11, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("nopop_credit_usage", 160'(usage_o), 160'(2));
    chk("nopop_credit_cnt", 160'(drop_cnt_o), 160'(3));
    repeat (4) step('0, 1'b1, 1'b0);

    rand_data();
    s_itype[0] = 3'd1;
    s_cause    = 32'h2;
    s_tval     = 32'hDEAD;
    s_priv     = 2'd3;
    step(2'b01, 1'b1, 1'b0);
    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("clear_ovf", 160'(overflow_o), 160'(0));
    chk("clear_cnt", 160'(drop_cnt_o), 160'(0));

    for (int c = 0; c < 1500; c++) begin
      rand_data();
      step(N'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);
    end

    rand_data(); step(2'b11, 1'b0, 1'b0);
    rand_data(); step(2'b11, 1'b0, 1'b0);
    do_reset();
    repeat (2) step('0, 1'b1, 1'b0);

    for (int c = 0; c < 300; c++) begin
      rand_data();
      step(N'($urandom), $urandom_range(0, 1) != 0, 1'b0);
    end
    repeat (DEPTH + 2) step('0, 1'b1, 1'b0);
    @(negedge clk_i);
    #1;
    chk("all_blocks_seen", 160'(exp_q.size()), 160'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
